// File: rtl/s100_int_controller_pkg.sv
// Shared constants, FSM state type and priority helpers for the S100 Z80
// mode-0 interrupt controller.
package s100_int_controller_pkg;

  localparam int NUM_SRC = 8;
  localparam int IDX_W = $clog2(NUM_SRC);

  // RST 00h opcode; the source index lands in bits [5:3].
  localparam logic [7:0] RST_BASE = 8'hC7;
  // RST 38h, also what a floating data bus reads as.
  localparam logic [7:0] SPURIOUS_VEC = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACK    = 2'd2
  } state_e;

  // Bits strictly above the highest set bit of isr; all ones when isr is zero.
  function automatic logic [NUM_SRC-1:0] above_mask(input logic [NUM_SRC-1:0] isr);
    logic [NUM_SRC-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      m[i] = ~|(isr >> i);
    end
    return m;
  endfunction

  // One-hot of the highest set bit of v (zero when v is zero).
  function automatic logic [NUM_SRC-1:0] highest_onehot(input logic [NUM_SRC-1:0] v);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      oh[i] = v[i] & ~|(v >> (i + 1));
    end
    return oh;
  endfunction

  // Binary index of a one-hot vector.
  function automatic logic [IDX_W-1:0] onehot_index(input logic [NUM_SRC-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = idx | ({IDX_W{oh[i]}} & IDX_W'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/s100_int_controller_if.sv
// CPU-side and register-side signals of the interrupt controller.
interface s100_int_controller_if;
  import s100_int_controller_pkg::*;

  logic               n_m1;
  logic               n_iorq;
  logic               mask_wr;
  logic [NUM_SRC-1:0] mask_din;
  logic               eoi;
  logic               z80_int_n;
  logic [7:0]         vec_out;
  logic               vec_oe;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;

  // CPU / host side
  modport master (
    output n_m1, n_iorq, mask_wr, mask_din, eoi,
    input  z80_int_n, vec_out, vec_oe, mask_q, pending, in_service
  );

  // Interrupt controller side
  modport slave (
    input  n_m1, n_iorq, mask_wr, mask_din, eoi,
    output z80_int_n, vec_out, vec_oe, mask_q, pending, in_service
  );

endinterface

// File: rtl/s100_int_controller_irq_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input, with an optional
// single-clock rising-edge pulse taken from the synchronized output.
module irq_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw input through the synchronizer chain, stage 0 first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_r;

      // Remember the last synchronized value so a held level pulses once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_r <= RST_VAL;
        end else begin
          prev_r <= q;
        end
      end

      assign rise = q & ~prev_r;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/s100_int_controller.sv
// Z80 mode-0 interrupt controller: latches synchronized request edges,
// applies mask and in-service nesting, drives /INT and supplies an RST
// opcode during the interrupt-acknowledge cycle.
module s100_int_controller
  import s100_int_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 pll0_250MHz,
  input  logic                 n_reset,
  input  logic [NUM_SRC-1:0]   irq_in,
  s100_int_controller_if.slave bus
);

  logic [NUM_SRC-1:0] irq_sync_s;
  logic [NUM_SRC-1:0] irq_rise_s;
  logic               m1_sync_s;
  logic               iorq_sync_s;
  logic [1:0]         ctl_rise_unused_s;

  state_e             state_r;
  state_e             state_s;
  logic [NUM_SRC-1:0] mask_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] in_service_r;
  logic               z80_int_n_r;
  logic [7:0]         vec_out_r;
  logic               vec_oe_r;

  logic [NUM_SRC-1:0] elig_s;
  logic [NUM_SRC-1:0] win_oh_s;
  logic [IDX_W-1:0]   win_s;
  logic [7:0]         vector_s;
  logic               inta_s;
  logic               ack_enter_s;
  logic               ack_valid_s;
  logic [NUM_SRC-1:0] ack_set_s;
  logic [NUM_SRC-1:0] eoi_clr_s;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_irq_sync
      irq_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync (
        .clk   (pll0_250MHz),
        .rst_n (n_reset),
        .d     (irq_in[gi]),
        .q     (irq_sync_s[gi]),
        .rise  (irq_rise_s[gi])
      );
    end
  endgenerate

  // CPU strobes idle high, so their synchronizers reset to 1.
  irq_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b0)) u_m1_sync (
    .clk   (pll0_250MHz),
    .rst_n (n_reset),
    .d     (bus.n_m1),
    .q     (m1_sync_s),
    .rise  (ctl_rise_unused_s[0])
  );

  irq_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b0)) u_iorq_sync (
    .clk   (pll0_250MHz),
    .rst_n (n_reset),
    .d     (bus.n_iorq),
    .q     (iorq_sync_s),
    .rise  (ctl_rise_unused_s[1])
  );

  // The level itself is only consumed through its edge pulse.
  logic [NUM_SRC-1:0] irq_level_unused_s;
  assign irq_level_unused_s = irq_sync_s;

  assign elig_s      = pending_r & ~mask_r & above_mask(in_service_r);
  assign win_oh_s    = highest_onehot(elig_s);
  assign win_s       = onehot_index(win_oh_s);
  assign vector_s    = RST_BASE | (8'(win_s) << 3);
  assign inta_s      = ~m1_sync_s & ~iorq_sync_s;
  assign ack_enter_s = (state_r == ASSERT) && inta_s;
  assign ack_valid_s = ack_enter_s && (elig_s != '0);
  assign ack_set_s   = win_oh_s & {NUM_SRC{ack_valid_s}};
  assign eoi_clr_s   = highest_onehot(in_service_r) & {NUM_SRC{bus.eoi}};

  // Next-state logic; INTA wins over a request vanishing in the same clock.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (elig_s != '0) begin
          state_s = ASSERT;
        end else begin
          state_s = IDLE;
        end
      end
      ASSERT: begin
        if (inta_s) begin
          state_s = ACK;
        end else if (elig_s == '0) begin
          state_s = IDLE;
        end else begin
          state_s = ASSERT;
        end
      end
      ACK: begin
        if (inta_s) begin
          state_s = ACK;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered CPU-facing outputs.
  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      state_r     <= IDLE;
      z80_int_n_r <= 1'b1;
      vec_oe_r    <= 1'b0;
      vec_out_r   <= SPURIOUS_VEC;
    end else begin
      state_r     <= state_s;
      z80_int_n_r <= (state_s != ASSERT);
      vec_oe_r    <= (state_s == ACK);
      if (ack_enter_s) begin
        vec_out_r <= ack_valid_s ? vector_s : SPURIOUS_VEC;
      end else if (state_s != ACK) begin
        vec_out_r <= SPURIOUS_VEC;
      end
    end
  end

  // Mask, pending and in-service registers; a new edge beats the ACK clear.
  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      mask_r       <= {NUM_SRC{1'b1}};
      pending_r    <= '0;
      in_service_r <= '0;
    end else begin
      if (bus.mask_wr) begin
        mask_r <= bus.mask_din;
      end
      pending_r    <= (pending_r & ~ack_set_s) | irq_rise_s;
      in_service_r <= (in_service_r & ~eoi_clr_s) | ack_set_s;
    end
  end

  assign bus.z80_int_n  = z80_int_n_r;
  assign bus.vec_out    = vec_out_r;
  assign bus.vec_oe     = vec_oe_r;
  assign bus.mask_q     = mask_r;
  assign bus.pending    = pending_r;
  assign bus.in_service = in_service_r;

endmodule

// File: tb/tb_s100_int_controller.sv
// Directed bench for s100_int_controller: a priority/vector table plus
// hand-written nesting, masking, spurious and reset sequences.
module tb_s100_int_controller;
  import s100_int_controller_pkg::*;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] irq_in;

  s100_int_controller_if bus();

  s100_int_controller dut (
    .pll0_250MHz (clk),
    .n_reset     (n_reset),
    .irq_in      (irq_in),
    .bus         (bus)
  );

  // 250 MHz clock
  always #2 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] irq;
    logic [7:0] vec;
    logic [7:0] isr;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.n_m1     = 1'b1;
    bus.n_iorq   = 1'b1;
    bus.mask_wr  = 1'b0;
    bus.mask_din = 8'h00;
    bus.eoi      = 1'b0;
  endtask

  task automatic do_reset();
    irq_in = 8'h00;
    idle_inputs();
    n_reset = 1'b0;
    repeat (2) tick();
    n_reset = 1'b1;
    tick();
  endtask

  task automatic set_mask(input logic [7:0] m);
    bus.mask_din = m;
    bus.mask_wr  = 1'b1;
    tick();
    bus.mask_wr  = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
  endtask

  task automatic wait_int(input string nm);
    for (int k = 0; k < 16 && bus.z80_int_n !== 1'b0; k++) tick();
    chk1(nm, bus.z80_int_n, 1'b0);
  endtask

  task automatic inta_on(input string nm);
    bus.n_m1   = 1'b0;
    bus.n_iorq = 1'b0;
    for (int k = 0; k < 16 && bus.vec_oe !== 1'b1; k++) tick();
    chk1(nm, bus.vec_oe, 1'b1);
  endtask

  task automatic inta_off(input string nm);
    bus.n_m1   = 1'b1;
    bus.n_iorq = 1'b1;
    for (int k = 0; k < 16 && bus.vec_oe !== 1'b0; k++) tick();
    chk1(nm, bus.vec_oe, 1'b0);
  endtask

  initial begin
    //          mask    irq     vec     isr     pend
    tbl[0] = '{8'h00, 8'h01, 8'hC7, 8'h01, 8'h00};
    tbl[1] = '{8'h00, 8'h0F, 8'hDF, 8'h08, 8'h07};
    tbl[2] = '{8'h80, 8'hC0, 8'hF7, 8'h40, 8'h80};
    tbl[3] = '{8'hF0, 8'hFF, 8'hDF, 8'h08, 8'hF7};
    tbl[4] = '{8'h00, 8'h24, 8'hEF, 8'h20, 8'h04};
    tbl[5] = '{8'h7F, 8'h81, 8'hFF, 8'h80, 8'h01};
    tbl[6] = '{8'hFE, 8'h03, 8'hC7, 8'h01, 8'h02};

    // Reset values and single-source path with exact capture latency
    do_reset();
    chk1("rst_int_n", bus.z80_int_n, 1'b1);
    chk ("rst_vec_out", bus.vec_out, 8'hFF);
    chk1("rst_vec_oe", bus.vec_oe, 1'b0);
    chk ("rst_mask", bus.mask_q, 8'hFF);
    chk ("rst_pending", bus.pending, 8'h00);
    chk ("rst_isr", bus.in_service, 8'h00);
    set_mask(8'h00);
    irq_in[3] = 1'b1;
    repeat (2) tick();
    chk ("t1_pend_2clk", bus.pending, 8'h00);
    tick();
    chk ("t1_pend_3clk", bus.pending, 8'h08);
    chk1("t1_int_3clk", bus.z80_int_n, 1'b1);
    tick();
    chk1("t1_int_4clk", bus.z80_int_n, 1'b0);
    inta_on("t1_ack");
    chk ("t1_vec", bus.vec_out, 8'hDF);
    chk ("t1_isr", bus.in_service, 8'h08);
    chk ("t1_pend_clr", bus.pending, 8'h00);
    chk1("t1_int_rel", bus.z80_int_n, 1'b1);
    inta_off("t1_rel");
    repeat (4) tick();
    chk ("t1_level_no_retrig", bus.pending, 8'h00);

    // Nesting: higher source preempts, lower one waits for both EOIs
    irq_in[6] = 1'b1;
    wait_int("t3_int6");
    inta_on("t3_ack6");
    chk ("t3_vec6", bus.vec_out, 8'hF7);
    chk ("t3_isr6", bus.in_service, 8'h48);
    inta_off("t3_rel6");
    irq_in[2] = 1'b1;
    repeat (6) tick();
    chk1("t3_low_blocked", bus.z80_int_n, 1'b1);
    chk ("t3_pend2", bus.pending, 8'h04);
    pulse_eoi();
    chk ("t3_eoi1", bus.in_service, 8'h08);
    repeat (4) tick();
    chk1("t3_still_blocked", bus.z80_int_n, 1'b1);
    pulse_eoi();
    chk ("t3_eoi2", bus.in_service, 8'h00);
    wait_int("t3_int2");
    inta_on("t3_ack2");
    chk ("t3_vec2", bus.vec_out, 8'hD7);
    inta_off("t3_rel2");
    pulse_eoi();

    // Simultaneous rise of 7 and 4; EOI and mask write in one clock
    do_reset();
    set_mask(8'h00);
    irq_in = 8'h90;
    wait_int("t2_int7");
    inta_on("t2_ack7");
    chk ("t2_vec7", bus.vec_out, 8'hFF);
    chk ("t2_isr7", bus.in_service, 8'h80);
    chk ("t2_pend4", bus.pending, 8'h10);
    inta_off("t2_rel7");
    repeat (4) tick();
    chk1("t2_4_blocked", bus.z80_int_n, 1'b1);
    pulse_eoi();
    wait_int("t2_int4");
    inta_on("t2_ack4");
    chk ("t2_vec4", bus.vec_out, 8'hE7);
    inta_off("t2_rel4");
    bus.mask_din = 8'h0F;
    bus.mask_wr  = 1'b1;
    bus.eoi      = 1'b1;
    tick();
    bus.mask_wr  = 1'b0;
    bus.eoi      = 1'b0;
    chk ("t2_mask_eoi_mask", bus.mask_q, 8'h0F);
    chk ("t2_mask_eoi_isr", bus.in_service, 8'h00);
    pulse_eoi();
    chk ("t2_eoi_empty", bus.in_service, 8'h00);

    // Mask before INTA withdraws /INT but keeps pending
    do_reset();
    set_mask(8'h00);
    irq_in = 8'h20;
    wait_int("t4_int");
    set_mask(8'hFF);
    tick();
    chk1("t4_int_drop", bus.z80_int_n, 1'b1);
    chk ("t4_pend", bus.pending, 8'h20);

    // Mask lands in the same clock INTA is sampled -> spurious vector
    set_mask(8'h00);
    wait_int("t5_int");
    bus.n_m1   = 1'b0;
    bus.n_iorq = 1'b0;
    tick();
    bus.mask_din = 8'hFF;
    bus.mask_wr  = 1'b1;
    tick();
    bus.mask_wr  = 1'b0;
    for (int k = 0; k < 16 && bus.vec_oe !== 1'b1; k++) tick();
    chk1("t5_ack", bus.vec_oe, 1'b1);
    chk ("t5_vec_spur", bus.vec_out, 8'hFF);
    chk ("t5_isr", bus.in_service, 8'h00);
    chk ("t5_pend", bus.pending, 8'h20);

    // Asynchronous reset while driving the vector
    n_reset = 1'b0;
    #1;
    chk1("t6_oe", bus.vec_oe, 1'b0);
    chk1("t6_int", bus.z80_int_n, 1'b1);
    chk ("t6_mask", bus.mask_q, 8'hFF);
    chk ("t6_pend", bus.pending, 8'h00);
    idle_inputs();
    irq_in = 8'h00;
    tick();
    n_reset = 1'b1;
    tick();

    // Priority / mask / vector table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      set_mask(tbl[i].mask);
      irq_in = tbl[i].irq;
      wait_int($sformatf("tbl%0d_int", i));
      inta_on($sformatf("tbl%0d_ack", i));
      chk($sformatf("tbl%0d_vec", i), bus.vec_out, tbl[i].vec);
      chk($sformatf("tbl%0d_isr", i), bus.in_service, tbl[i].isr);
      chk($sformatf("tbl%0d_pend", i), bus.pending, tbl[i].pend);
      inta_off($sformatf("tbl%0d_rel", i));
      irq_in = 8'h00;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
